// File: rtl/ram_responder.sv
// Line-oriented RAM responder: one request moves a whole line as BEATS word beats.
// Unwritten lines read back a beat-indexed address pattern instead of stale storage.
module ram_responder #(
    parameter int ADDR_SIZE    = 13,
    parameter int WORD_SIZE    = 16,
    parameter int LINE_WIDTH   = 64,
    parameter int READ_LATENCY = 2     // legal range 0..15
) (
    input  logic                  ram_clk,
    input  logic                  ram_rst_n,
    input  logic [ADDR_SIZE-1:0]  ram_addr,
    input  logic                  ram_avalid,
    input  logic                  ram_rnw,
    input  logic [WORD_SIZE-1:0]  ram_wdata,
    output logic [WORD_SIZE-1:0]  ram_rdata,
    output logic                  ram_ack,
    output logic [LINE_WIDTH-1:0] data_backdoor
);

    localparam int BEATS  = LINE_WIDTH / WORD_SIZE;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEPTH  = 2 ** ADDR_SIZE;
    localparam int PAT_AW = (ADDR_SIZE < WORD_SIZE - 3) ? ADDR_SIZE : WORD_SIZE - 3;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [3:0]    WAIT_INIT = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_ACK,
        RD_WAIT,
        RD_BURST
    } state_t;

    state_t                 r_state;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [BW-1:0]          r_beat;
    logic [3:0]             r_wait;
    logic [WORD_SIZE-1:0]   r_wbeat [BEATS-1];
    logic [LINE_WIDTH-1:0]  r_backdoor;
    logic                   r_ack;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic [DEPTH-1:0]       r_written;
    logic [LINE_WIDTH-1:0]  r_mem [DEPTH];

    logic                   w_commit;
    logic [LINE_WIDTH-1:0]  w_commit_line;
    logic [LINE_WIDTH-1:0]  w_stored_line;

    // Beat k of an unwritten line: {k[1:0], 1'b0, addr}, beat 0 in the low word.
    function automatic logic [LINE_WIDTH-1:0] default_line(input logic [ADDR_SIZE-1:0] a);
        logic [LINE_WIDTH-1:0] l;
        logic [WORD_SIZE-1:0]  b;
        l = '0;
        for (int k = 0; k < BEATS; k++) begin
            b                    = '0;
            b[WORD_SIZE-1 -: 2]  = 2'(k);
            b[PAT_AW-1:0]        = a[PAT_AW-1:0];
            l[k*WORD_SIZE +: WORD_SIZE] = b;
        end
        return l;
    endfunction

    assign w_commit = (r_state == WR_COLLECT) && (r_beat == LAST_BEAT);

    // NOTE: every always_comb output gets a full default first so no path can infer a latch.
    always_comb begin
        w_commit_line = '0;
        for (int k = 0; k < BEATS - 1; k++) begin
            w_commit_line[k*WORD_SIZE +: WORD_SIZE] = r_wbeat[k];
        end
        w_commit_line[(BEATS-1)*WORD_SIZE +: WORD_SIZE] = ram_wdata;
        w_stored_line = r_written[ram_addr] ? r_mem[ram_addr] : default_line(ram_addr);
    end

    // NOTE: the line store has no reset; clearing the written-flags is what makes it look empty.
    always_ff @(posedge ram_clk) begin
        if (w_commit) begin
            r_mem[r_addr] <= w_commit_line;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_beat     <= '0;
            r_wait     <= '0;
            r_backdoor <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_written  <= '0;
            for (int k = 0; k < BEATS - 1; k++) begin
                r_wbeat[k] <= '0;
            end
        end else begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            unique case (r_state)
                IDLE: begin
                    if (ram_avalid) begin
                        r_addr     <= ram_addr;
                        r_backdoor <= w_stored_line;
                        if (ram_rnw) begin
                            r_beat  <= '0;
                            r_wait  <= WAIT_INIT;
                            r_state <= (READ_LATENCY == 0) ? RD_BURST : RD_WAIT;
                        end else begin
                            r_wbeat[0] <= ram_wdata;
                            r_beat     <= BW'(1);
                            r_state    <= WR_COLLECT;
                        end
                    end
                end
                WR_COLLECT: begin
                    if (r_beat == LAST_BEAT) begin
                        r_written[r_addr] <= 1'b1;
                        r_backdoor        <= w_commit_line;
                        r_state           <= WR_ACK;
                    end else begin
                        r_wbeat[r_beat] <= ram_wdata;
                        r_beat          <= r_beat + 1'b1;
                    end
                end
                WR_ACK: begin
                    r_ack   <= 1'b1;
                    r_state <= IDLE;
                end
                RD_WAIT: begin
                    if (r_wait == 4'd0) begin
                        r_state <= RD_BURST;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                RD_BURST: begin
                    // No write can land during a read, so the latched line is the source.
                    r_ack   <= 1'b1;
                    r_rdata <= r_backdoor[int'(r_beat)*WORD_SIZE +: WORD_SIZE];
                    if (r_beat == LAST_BEAT) begin
                        r_state <= IDLE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ram_ack       = r_ack;
    assign ram_rdata     = r_rdata;
    assign data_backdoor = r_backdoor;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: latency-2 and latency-0 builds share one stimulus stream
// and are checked cycle by cycle against a line/flag array model.
module tb_ram_responder;

    localparam int AW = 13;
    localparam int WW = 16;
    localparam int LW = 64;

    logic          ram_clk    = 1'b0;
    logic          ram_rst_n  = 1'b0;
    logic [AW-1:0] ram_addr   = '0;
    logic          ram_avalid = 1'b0;
    logic          ram_rnw    = 1'b0;
    logic [WW-1:0] ram_wdata  = '0;

    logic [WW-1:0] rdata2, rdata0;
    logic          ack2, ack0;
    logic [LW-1:0] bd2, bd0;

    always #5 ram_clk = ~ram_clk;

    ram_responder #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LINE_WIDTH(LW), .READ_LATENCY(2)) u_dut2 (
        .ram_clk(ram_clk), .ram_rst_n(ram_rst_n), .ram_addr(ram_addr), .ram_avalid(ram_avalid),
        .ram_rnw(ram_rnw), .ram_wdata(ram_wdata), .ram_rdata(rdata2), .ram_ack(ack2),
        .data_backdoor(bd2)
    );

    ram_responder #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LINE_WIDTH(LW), .READ_LATENCY(0)) u_dut0 (
        .ram_clk(ram_clk), .ram_rst_n(ram_rst_n), .ram_addr(ram_addr), .ram_avalid(ram_avalid),
        .ram_rnw(ram_rnw), .ram_wdata(ram_wdata), .ram_rdata(rdata0), .ram_ack(ack0),
        .data_backdoor(bd0)
    );

    logic [LW-1:0] m_mem     [2**AW];
    bit            m_written [2**AW];

    int checks = 0;
    int errors = 0;

    function automatic logic [LW-1:0] exp_line(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        if (m_written[a]) return m_mem[a];
        l = '0;
        for (int k = 0; k < 4; k++) begin
            l[k*16 +: 16] = 16'(k * 16384 + int'(a));
        end
        return l;
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ack2"},   64'(ack2),   64'd0);
        check({tag, "_rdata2"}, 64'(rdata2), 64'd0);
        check({tag, "_ack0"},   64'(ack0),   64'd0);
        check({tag, "_rdata0"}, 64'(rdata0), 64'd0);
    endtask

    // Write a whole line; with stray set, a read request is pulsed mid-collection.
    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] line, input bit stray);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
        ram_addr   = a;
        ram_wdata  = line[15:0];
        step();
        ram_avalid = 1'b0;
        ram_addr   = AW'($urandom);
        ram_rnw    = 1'($urandom);
        check("wr_bd_accept2", bd2, exp_line(a));
        check("wr_bd_accept0", bd0, exp_line(a));
        for (int c = 1; c <= 3; c++) begin
            ram_wdata = line[c*16 +: 16];
            if (stray && c == 2) begin
                ram_avalid = 1'b1;
                ram_rnw    = 1'b1;
                ram_addr   = a ^ AW'(1);
            end
            check_quiet("wr_collect");
            step();
            ram_avalid = 1'b0;
        end
        m_mem[a]     = line;
        m_written[a] = 1'b1;
        ram_wdata    = WW'($urandom);
        check_quiet("wr_commit");
        check("wr_bd_commit2", bd2, line);
        check("wr_bd_commit0", bd0, line);
        step();
        check("wr_ack2",   64'(ack2),   64'd1);
        check("wr_ack0",   64'(ack0),   64'd1);
        check("wr_rdata2", 64'(rdata2), 64'd0);
        check("wr_rdata0", 64'(rdata0), 64'd0);
    endtask

    // Read a line; cycle c counts edges after accept (accept edge = cycle 0).
    task automatic do_read(input logic [AW-1:0] a);
        logic [LW-1:0] e;
        logic          ea2, ea0;
        logic [WW-1:0] ed2, ed0;
        e          = exp_line(a);
        ram_avalid = 1'b1;
        ram_rnw    = 1'b1;
        ram_addr   = a;
        ram_wdata  = WW'($urandom);
        step();
        ram_avalid = 1'b0;
        ram_addr   = AW'($urandom);
        ram_rnw    = 1'($urandom);
        check("rd_bd2", bd2, e);
        check("rd_bd0", bd0, e);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) step();
            ram_wdata = WW'($urandom);
            ea2 = (c >= 3 && c <= 6);
            ea0 = (c >= 1 && c <= 4);
            ed2 = ea2 ? e[(c-3)*16 +: 16] : '0;
            ed0 = ea0 ? e[(c-1)*16 +: 16] : '0;
            check("rd_ack2",   64'(ack2),   64'(ea2));
            check("rd_rdata2", 64'(rdata2), 64'(ed2));
            check("rd_ack0",   64'(ack0),   64'(ea0));
            check("rd_rdata0", 64'(rdata0), 64'(ed0));
        end
    endtask

    initial begin
        logic [AW-1:0] pool [5];
        logic [AW-1:0] a;

        #2;
        check_quiet("reset");
        check("reset_bd2", bd2, 64'd0);
        check("reset_bd0", bd0, 64'd0);
        step();
        step();
        ram_rst_n = 1'b1;

        do_read(13'h1579);

        do_write(13'h0155, 64'h1234F00DDEADBEEF, 1'b0);
        do_read(13'h0155);

        do_write(13'h0000, 64'h0123456789ABCDEF, 1'b0);
        do_write(13'h1FFF, 64'hFEDCBA9876543210, 1'b0);
        do_read(13'h0000);
        do_read(13'h1FFF);

        do_write(13'h0321, 64'hA5A55A5AC3C33C3C, 1'b1);
        do_read(13'h0321);
        do_read(13'h0320);

        do_write(13'h0777, 64'h0F0F1E1E2D2D3C3C, 1'b0);
        do_read(13'h0777);

        // Reset lands after beat 2 of a write; nothing may be committed.
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
        ram_addr   = 13'h0AAA;
        ram_wdata  = 16'h1111;
        step();
        ram_avalid = 1'b0;
        ram_wdata  = 16'h2222;
        step();
        ram_wdata  = 16'h3333;
        step();
        ram_rst_n  = 1'b0;
        ram_wdata  = 16'h4444;
        #1;
        foreach (m_written[i]) m_written[i] = 1'b0;
        check_quiet("rst_mid");
        check("rst_mid_bd2", bd2, 64'd0);
        check("rst_mid_bd0", bd0, 64'd0);
        step();
        step();
        check_quiet("rst_hold");
        ram_rst_n = 1'b1;
        do_read(13'h0AAA);
        do_read(13'h0777);

        pool[0] = 13'h0000;
        pool[1] = 13'h1FFF;
        pool[2] = AW'($urandom);
        pool[3] = AW'($urandom);
        pool[4] = AW'($urandom);
        for (int t = 0; t < 24; t++) begin
            a = pool[$urandom_range(0, 4)];
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, {$urandom, $urandom}, $urandom_range(0, 3) == 0);
            end else begin
                do_read(a);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 13, line address width.
REQ-002 SHALL have parameter WORD_SIZE, default 16, beat width.
REQ-003 SHALL have parameter LINE_WIDTH, default 64, line width; beats per line BEATS = LINE_WIDTH/WORD_SIZE (4).
REQ-004 SHALL have parameter READ_LATENCY, default 2, idle cycles before the first read beat; legal range 0..15.
REQ-005 SHALL have port ram_clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port ram_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port ram_addr  input  ADDR_SIZE  line address, sampled with ram_avalid.
REQ-008 SHALL have port ram_avalid  input  1  request strobe, one cycle per request.
REQ-009 SHALL have port ram_rnw  input  1  1 = read line, 0 = write line; sampled with ram_avalid.
REQ-010 SHALL have port ram_wdata  input  WORD_SIZE  write beat data.
REQ-011 SHALL have port ram_rdata  output  WORD_SIZE  read beat data.
REQ-012 SHALL have port ram_ack  output  1  read beat valid, or write-complete pulse.
REQ-013 SHALL have port data_backdoor  output  LINE_WIDTH  current contents of the line most recently addressed (read or write).

Function
REQ-014 SHALL store 2^ADDR_SIZE lines of LINE_WIDTH bits, plus one written-flag per line.
REQ-015 SHALL return, for a line whose written-flag is 0, the default pattern: beat k = {k[1:0], 1'b0, addr[12:0]} (k = 0 is the first beat, least-significant 16 bits of the line).
REQ-016 SHALL implement FSM states IDLE, WR_COLLECT, WR_ACK, RD_WAIT, RD_BURST.
REQ-017 SHALL, in IDLE, accept a request only on a ram_clk edge with ram_avalid = 1, latching ram_addr and ram_rnw.
REQ-018 SHALL, for a write, capture beat 0 from ram_wdata on the accept edge and beats 1..3 on the next three edges (state WR_COLLECT); beat k fills line bits [16k+15:16k].
REQ-019 SHALL commit the full line and set its written-flag on the edge that captures beat 3, then enter WR_ACK.
REQ-020 SHALL assert ram_ack for exactly one cycle in WR_ACK (cycle 4 after accept), then return to IDLE; ram_rdata is 0 during write.
REQ-021 SHALL, for a read, wait READ_LATENCY cycles in RD_WAIT (skipped when 0), then drive 4 consecutive beats in RD_BURST, ram_ack = 1 on each; the first beat appears READ_LATENCY+1 cycles after accept.
REQ-022 SHALL drive ram_ack and ram_rdata from registers; ram_rdata = 0 whenever ram_ack = 0.
REQ-023 SHALL return to IDLE on the edge after the last read beat; ram_ack then deasserts with no gap cycle required before the next accept.
REQ-024 SHALL ignore ram_avalid in any state other than IDLE (no queueing, no state change).
REQ-025 SHALL ignore ram_wdata outside WR_COLLECT and the accept edge of a write.
REQ-026 SHALL wrap no addresses: each request touches exactly one line; addresses 0 and 2^ADDR_SIZE-1 are both valid.
REQ-027 SHALL return data committed by a write to the same address on any later read (read-after-write, including back-to-back).
REQ-028 SHALL update data_backdoor to the addressed line on the accept edge, and to the new line value on the commit edge of a write.

Reset
REQ-029 SHALL, on ram_rst_n = 0, immediately force state IDLE, ram_ack = 0, ram_rdata = 0, data_backdoor = 0, and clear all written-flags.
REQ-030 SHALL abandon any in-flight burst on reset; a partially collected write SHALL NOT be committed.
REQ-031 SHALL accept a request on the first rising edge after ram_rst_n deasserts.

Verification
REQ-032 Read unwritten addr 0x1579, READ_LATENCY = 2 -> ram_ack high cycles 3..6, beats 0x1579, 0x5579, 0x9579, 0xD579.
REQ-033 Write addr 0x0155 beats 0xBEEF, 0xDEAD, 0xF00D, 0x1234 -> single ram_ack pulse at cycle 4, data_backdoor = 0x1234F00DDEADBEEF; subsequent read returns the same 4 beats in order.
REQ-034 Write addr 0x0000 and addr 0x1FFF with distinct data, read both -> each returns its own data (boundary addresses, no aliasing).
REQ-035 ram_avalid pulsed with ram_rnw = 1 during a write's WR_COLLECT -> ignored; only the write's ram_ack pulse occurs, line contents unchanged by the stray request.
REQ-036 Assert ram_rst_n = 0 after beat 2 of a write to addr 0x0AAA -> ram_ack stays 0; after release, read of 0x0AAA returns default pattern 0x0AAA, 0x4AAA, 0x8AAA, 0xCAAA.
REQ-037 READ_LATENCY = 0 build, read immediately following a write ack -> first beat one cycle after accept, data equals the just-written line.
